// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
package spi_arb_pkg;

    localparam int SPI_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        BUSY,
        GAP
    } arb_state_t;

endpackage

// File: rtl/spi_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to
// the port that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last_gnt;
            default: gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between two requesters: round-robin grant, one
// transaction per grant, watchdog on a hung master, SS_n gap between launches.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1023,
    parameter int GAP_CYC     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [SPI_W-1:0] cmd0,
    input  logic             req1,
    input  logic [SPI_W-1:0] cmd1,
    output logic             rdy0,
    output logic             rdy1,
    output logic             err0,
    output logic             err1,
    output logic [SPI_W-1:0] resp_data,
    output logic             busy,
    output logic             spi_wrt,
    output logic [SPI_W-1:0] spi_cmd,
    input  logic             spi_done,
    input  logic [SPI_W-1:0] spi_rd_data
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]      GAP_LAST = 8'(GAP_CYC - 1);

    arb_state_t       state_reg, state_next;
    logic             gnt_id_reg;
    logic             last_gnt_reg;
    logic [SPI_W-1:0] spi_cmd_reg;
    logic [SPI_W-1:0] resp_reg;
    logic [WD_W-1:0]  wdog_reg;
    logic [7:0]       gap_reg;
    logic [1:0]       rdy_reg;
    logic [1:0]       err_reg;
    logic [1:0]       port_hit;

    logic arb_valid;
    logic arb_id;
    logic done_evt;
    logic tmo_evt;

    rr_arb2 u_rr_arb2 (
        .req       ({req1, req0}),
        .last_gnt  (last_gnt_reg),
        .gnt_valid (arb_valid),
        .gnt_id    (arb_id)
    );

    // Done wins over timeout when both land in the same BUSY cycle.
    assign done_evt = (state_reg == BUSY) && spi_done;
    assign tmo_evt  = (state_reg == BUSY) && !spi_done && (wdog_reg == WD_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign port_hit[gi] = (gnt_id_reg == 1'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (arb_valid) state_next = LAUNCH;
            LAUNCH:  state_next = SETTLE;
            SETTLE:  state_next = BUSY;
            BUSY:    if (done_evt || tmo_evt) state_next = GAP;
            GAP:     if (gap_reg == GAP_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            gnt_id_reg   <= 1'b0;
            last_gnt_reg <= 1'b1;
            spi_cmd_reg  <= '0;
            resp_reg     <= '0;
            wdog_reg     <= '0;
            gap_reg      <= '0;
            rdy_reg      <= '0;
            err_reg      <= '0;
        end else begin
            state_reg <= state_next;
            rdy_reg   <= done_evt ? port_hit : 2'b00;
            err_reg   <= tmo_evt  ? port_hit : 2'b00;
            if (state_reg == IDLE && arb_valid) begin
                gnt_id_reg   <= arb_id;
                last_gnt_reg <= arb_id;
                spi_cmd_reg  <= arb_id ? cmd1 : cmd0;
            end
            // The master may still show the previous done in SETTLE, so the
            // watchdog starts from zero on the first BUSY cycle.
            if (state_reg == SETTLE)
                wdog_reg <= '0;
            else if (state_reg == BUSY)
                wdog_reg <= wdog_reg + WD_W'(1);
            if (state_reg == BUSY)
                gap_reg <= '0;
            else if (state_reg == GAP)
                gap_reg <= gap_reg + 8'(1);
            if (done_evt)
                resp_reg <= spi_rd_data;
            else if (tmo_evt)
                resp_reg <= '0;
        end
    end

    assign spi_wrt   = (state_reg == LAUNCH);
    assign busy      = (state_reg != IDLE);
    assign spi_cmd   = spi_cmd_reg;
    assign resp_data = resp_reg;
    assign rdy0      = rdy_reg[0];
    assign rdy1      = rdy_reg[1];
    assign err0      = err_reg[0];
    assign err1      = err_reg[1];

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a behavioural SPI master model.
module tb_spi_arbiter;

    localparam int GAP = 8;
    localparam int TMO = 1023;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] cmd0 = '0, cmd1 = '0;
    logic        rdy0, rdy1, err0, err1, busy, spi_wrt;
    logic [15:0] resp_data, spi_cmd;
    logic        spi_done = 1'b0;
    logic [15:0] spi_rd_data = '0;

    spi_arbiter #(.TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (req0),
        .cmd0        (cmd0),
        .req1        (req1),
        .cmd1        (cmd1),
        .rdy0        (rdy0),
        .rdy1        (rdy1),
        .err0        (err0),
        .err1        (err1),
        .resp_data   (resp_data),
        .busy        (busy),
        .spi_wrt     (spi_wrt),
        .spi_cmd     (spi_cmd),
        .spi_done    (spi_done),
        .spi_rd_data (spi_rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Master model: done is sticky, cleared one edge after wrt (two in
    // stale mode), then raised lat cycles later unless hang is set.
    int          slave_lat = 20;
    logic [15:0] slave_data = '0;
    logic        stale_mode = 1'b0;
    logic        hang = 1'b0;
    logic        active = 1'b0;
    logic        wrt_d = 1'b0;
    int          scnt = 0;

    always @(posedge clk) begin
        if (spi_wrt) begin
            active <= 1'b1;
            scnt   <= 0;
            wrt_d  <= 1'b1;
            if (!stale_mode) spi_done <= 1'b0;
        end else begin
            wrt_d <= 1'b0;
            if (wrt_d) spi_done <= 1'b0;
            if (active) begin
                if (!hang && scnt == slave_lat) begin
                    spi_done    <= 1'b1;
                    spi_rd_data <= slave_data;
                    active      <= 1'b0;
                end
                scnt <= scnt + 1;
            end
        end
    end

    int n_wrt = 0, n_rdy0 = 0, n_rdy1 = 0, n_err = 0;
    always @(negedge clk) begin
        if (spi_wrt) n_wrt++;
        if (rdy0) n_rdy0++;
        if (rdy1) n_rdy1++;
        if (err0 || err1) n_err++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_wrt(input int budget, output int at, output logic [15:0] c);
        at = -1;
        c  = 'x;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (spi_wrt) begin
                at = cyc;
                c  = spi_cmd;
                break;
            end
        end
    endtask

    task automatic wait_resp(input int budget, output int at, output logic [3:0] kind,
                             output logic [15:0] d);
        at   = -1;
        kind = 4'b0000;
        d    = 'x;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (rdy0 || rdy1 || err0 || err1) begin
                at   = cyc;
                kind = {err1, err0, rdy1, rdy0};
                d    = resp_data;
                break;
            end
        end
    endtask

    int          w, w2, r, t, c0;
    int          b_wrt, b_rdy0, b_rdy1, b_err;
    logic [3:0]  k;
    logic [15:0] c, d;

    initial begin
        // Reset state
        step(1);
        check("reset_outs", {rdy0, rdy1, err0, err1, busy, spi_wrt, resp_data, spi_cmd}, 0);
        step(1);
        rst_n = 1'b1;
        step(2);
        check("idle_busy", busy, 0);

        // Single request
        b_wrt = n_wrt; b_rdy0 = n_rdy0; b_rdy1 = n_rdy1; b_err = n_err;
        slave_lat = 20; slave_data = 16'h0A5C;
        cmd0 = 16'hC000; req0 = 1'b1; c0 = cyc;
        wait_wrt(20, w, c);
        check("single_wrt_lat", w, c0 + 1);
        check("single_cmd", c, 16'hC000);
        wait_resp(100, t, k, d);
        check("single_rdy_lat", t, w + 23);
        check("single_kind", k, 4'b0001);
        check("single_data", d, 16'h0A5C);
        $display("txn port=0 cmd=%h resp=%h wrt@%0d rdy@%0d", c, d, w, t);
        req0 = 1'b0;
        step(GAP + 6);
        check("single_nwrt", n_wrt - b_wrt, 1);
        check("single_nrdy0", n_rdy0 - b_rdy0, 1);
        check("single_nrdy1", n_rdy1 - b_rdy1, 0);
        check("single_nerr", n_err - b_err, 0);

        // Tie right after reset: port 0 first
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        cmd0 = 16'h0001; cmd1 = 16'h0002; slave_data = 16'h1111;
        req0 = 1'b1; req1 = 1'b1; c0 = cyc;
        wait_wrt(20, w, c);
        check("tie_first_lat", w, c0 + 1);
        check("tie_first_cmd", c, 16'h0001);
        wait_resp(100, t, k, d);
        check("tie_first_kind", k, 4'b0001);
        $display("txn port=0 cmd=%h resp=%h wrt@%0d rdy@%0d", c, d, w, t);
        req0 = 1'b0;
        slave_data = 16'h2222;
        wait_wrt(50, w2, c);
        check("tie_second_cmd", c, 16'h0002);
        check("tie_spacing", w2 - w, 22 + GAP + 2);
        wait_resp(100, t, k, d);
        check("tie_second_kind", k, 4'b0010);
        check("tie_second_data", d, 16'h2222);
        $display("txn port=1 cmd=%h resp=%h wrt@%0d rdy@%0d", c, d, w2, t);
        req1 = 1'b0;
        step(GAP + 4);

        // Saturation: both held for six transactions
        b_rdy0 = n_rdy0; b_rdy1 = n_rdy1;
        cmd0 = 16'hA000; cmd1 = 16'hB001;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_wrt(60, w, c);
            slave_data = 16'h1230 + 16'(i);
            check("sat_cmd", c, (i % 2 == 0) ? 16'hA000 : 16'hB001);
            wait_resp(100, t, k, d);
            check("sat_kind", k, (i % 2 == 0) ? 4'b0001 : 4'b0010);
            check("sat_data", d, 16'h1230 + 16'(i));
            $display("txn port=%0d cmd=%h resp=%h wrt@%0d rdy@%0d", i % 2, c, d, w, t);
        end
        req0 = 1'b0; req1 = 1'b0;
        step(GAP + 4);
        check("sat_nrdy0", n_rdy0 - b_rdy0, 3);
        check("sat_nrdy1", n_rdy1 - b_rdy1, 3);

        // Stale done held through SETTLE
        check("stale_done_pre", spi_done, 1);
        stale_mode = 1'b1; slave_data = 16'h5A5A;
        cmd0 = 16'h5555; req0 = 1'b1;
        wait_wrt(20, w, c);
        wait_resp(100, t, k, d);
        check("stale_rdy_lat", t, w + 23);
        check("stale_kind", k, 4'b0001);
        check("stale_data", d, 16'h5A5A);
        $display("txn port=0 cmd=%h resp=%h wrt@%0d rdy@%0d", c, d, w, t);
        req0 = 1'b0;
        stale_mode = 1'b0;
        step(GAP + 4);

        // Timeout on port 1
        hang = 1'b1;
        cmd1 = 16'h7E57; req1 = 1'b1;
        wait_wrt(20, w, c);
        check("tmo_cmd", c, 16'h7E57);
        wait_resp(1100, t, k, d);
        check("tmo_lat", t, w + 2 + TMO);
        check("tmo_kind", k, 4'b1000);
        check("tmo_data", d, 16'h0000);
        $display("txn port=1 cmd=%h resp=%h wrt@%0d err@%0d", c, d, w, t);
        req1 = 1'b0;
        step(GAP - 1);
        check("tmo_gap_busy", busy, 1);
        step(1);
        check("tmo_idle", busy, 0);
        hang = 1'b0;
        step(2);

        // Reset in the middle of BUSY
        slave_lat = 200; slave_data = 16'hDEAD;
        cmd0 = 16'h0BAD; req0 = 1'b1;
        wait_wrt(20, w, c);
        step(10);
        b_rdy0 = n_rdy0; b_err = n_err;
        rst_n = 1'b0;
        #1;
        check("abort_outs", {rdy0, rdy1, err0, err1, busy, spi_wrt, resp_data, spi_cmd}, 0);
        step(2);
        slave_lat = 20; slave_data = 16'hBEEF;
        rst_n = 1'b1; r = cyc;
        wait_wrt(10, w2, c);
        check("abort_regrant_lat", w2, r + 1);
        check("abort_regrant_cmd", c, 16'h0BAD);
        wait_resp(300, t, k, d);
        check("abort_rdy_lat", t, w2 + 23);
        check("abort_data", d, 16'hBEEF);
        $display("txn port=0 cmd=%h resp=%h wrt@%0d rdy@%0d", c, d, w2, t);
        req0 = 1'b0;
        step(GAP + 4);
        check("abort_nrdy0", n_rdy0 - b_rdy0, 1);
        check("abort_nerr", n_err - b_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
